sram_1rw1r_port_arbiter: RTL and testbench
==========================================

# sram_1rw1r_port_arbiter

Controller that shares one 1RW+1R OpenRAM SRAM macro (32x512 default) among three requesters: a masked-write stream (W), a read stream on the RW port (A) and a read stream on the R port (B). It owns the macro's port-0 and port-1 control pins, arbitrates W against A on port 0, and blocks a port-1 read that would hit the address being written in the same cycle. It also registers read data into per-stream response slots with valid/ready backpressure. It sits between the macro and the accelerator/memory-system logic, in the same clock domain as the macro.

## Interface
- DATA_WIDTH, 32, word width; equals macro data width
- ADDR_WIDTH, 9, word address width
- NUM_WMASKS, 32, write-mask bits; one per data bit (= DATA_WIDTH)

Ports:
- clk  in  1  single clock; also drives macro clk0 and clk1 externally
- reset  in  1  asynchronous, active-high
- w_req_valid / w_req_ready  in / out  1  write request handshake
- w_req_addr / w_req_data / w_req_mask  in  ADDR_WIDTH / DATA_WIDTH / NUM_WMASKS  write address, data and bit mask
- a_req_valid / a_req_ready  in / out  1  port-0 read request handshake
- a_req_addr  in  ADDR_WIDTH  port-0 read address
- a_resp_valid / a_resp_ready  out / in  1  port-0 read response handshake
- a_resp_data  out  DATA_WIDTH  port-0 read data
- b_req_valid / b_req_ready / b_req_addr  in / out / in  1 / 1 / ADDR_WIDTH  port-1 read request
- b_resp_valid / b_resp_ready / b_resp_data  out / in / out  1 / 1 / DATA_WIDTH  port-1 read response
- sram_csb0 / sram_web0  out  1  macro port-0 chip select and write enable, both active-low
- sram_wmask0 / sram_addr0 / sram_din0  out  NUM_WMASKS / ADDR_WIDTH / DATA_WIDTH  macro port-0 mask, address and write data
- sram_dout0  in  DATA_WIDTH  macro port-0 read data
- sram_csb1 / sram_addr1  out  1 / ADDR_WIDTH  macro port-1 chip select and address
- sram_dout1  in  DATA_WIDTH  macro port-1 read data

## Operation
- Fire means valid && ready at a rising edge. The macro samples its controls on that same edge. sram_* outputs are combinational from the firing request.
- Idle port: csb high. Idle port 0 also drives web0 high, addr0/din0/wmask0 = 0. Idle port 1 drives addr1 = 0.
- Port 0 write: csb0 = 0, web0 = 0, addr0/din0/wmask0 taken from the W request.
- Port 0 read: csb0 = 0, web0 = 1, addr0 = a_req_addr, wmask0 = 0.
- A is eligible when a_req_valid && (!a_resp_valid || a_resp_ready). B is eligible under the same rule on the B slot.
- Port-0 arbitration is round-robin between W and A, using a 1-bit pointer rr.
  - Only one eligible: that one is granted.
  - Both eligible: the side rr points to is granted, and rr flips to the other side.
  - rr does not change when there is no contention.
  - The loser's ready stays low and it retries the next cycle.
- Collision guard: b_req_ready = 0 in any cycle where W fires and b_req_addr == w_req_addr. B is accepted on a later cycle and returns the post-write data.
- B reads to any other address proceed in parallel with port-0 traffic.
- Read data return:
  - At the rising edge that ends the access cycle, sram_dout0 (or dout1) is captured into the A (or B) response register, and the matching resp_valid is set.
  - resp_valid clears on resp fire unless new data lands on the same edge.
  - resp_data holds stable while resp_valid && !resp_ready.
- A and B are independent and never reorder. There is one outstanding read per stream plus one buffered response.

## Timing
- Reset values: all resp_valid = 0, all resp_data = 0, rr = W. Request readies are combinational and therefore low in reset. csb0 = csb1 = 1, web0 = 1, other sram outputs 0.
- Reset is asynchronous, so asserting it mid-operation drops in-flight reads, and no response appears after reset.
- A write already sampled by the macro still completes; this is accepted behaviour.
- Read latency: request fires at edge t; resp_valid is high from edge t+1.
- Throughput: one read per cycle per stream while resp_ready stays high. Port 0 carries one access per cycle in total (W or A).
- Write-then-read to the same address:
  - W at edge t, A at edge t+1: A returns the new data.
  - W and B at the same edge and address: the guard holds B to t+1 at the earliest.
- Mask width rule: wmask bit i gates data bit i. A mask of 0 is legal; it performs no write but still occupies the cycle.
- Address wrap is the caller's concern; addresses pass through unmodified.

## Test plan
- Write addr 5, data 0x12345678, mask 0xFFFFFFFF; then A read addr 5 -> a_resp_valid one cycle after accept, a_resp_data = 0x12345678.
- Write addr 9 data 0 full mask; write addr 9 data 0xFFFFFFFF mask 0x0000FFFF; A read addr 9 -> 0x0000FFFF.
- W and A both held valid for 6 cycles after reset with responses drained -> grant order W,A,W,A,W,A; rr flips each cycle.
- W writes addr 7 = 0xA5A5A5A5 while B requests addr 7 the same cycle -> b_req_ready = 0 that cycle, B fires next cycle, returns 0xA5A5A5A5. Repeat with B addr 8 -> both fire the same cycle.
- A response pending with a_resp_ready = 0 for 3 cycles -> a_req_ready = 0 and a_resp_data stable. Raise ready -> next read accepted that cycle, no data lost or duplicated.
- Fire a B read, assert reset before the response edge -> b_resp_valid stays 0, all outputs at reset values. After release, a B read of a previously written address returns the correct data.

Source files
------------

// File: rtl/sram_1rw1r_port_arbiter.sv
// Shares a 1RW+1R SRAM macro between a masked-write stream (W) and a read stream (A) on port 0,
// and a read stream (B) on port 1, with registered read responses and valid/ready backpressure.

module sram_1rw1r_resp_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    input  logic                  resp_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  can_issue
);
    logic                  in_flight;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;

    // The skid entry catches a landing read when the consumer stalls on the same edge it arrives,
    // which would otherwise overwrite an unconsumed response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            in_flight <= issue;
            if (in_flight) begin
                if (!resp_valid || resp_ready) begin
                    resp_valid <= 1'b1;
                    resp_data  <= sram_dout;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= sram_dout;
                end
            end else if (resp_valid && resp_ready) begin
                if (skid_valid) begin
                    resp_data  <= skid_data;
                    skid_valid <= 1'b0;
                end else begin
                    resp_valid <= 1'b0;
                end
            end
        end
    end

    assign can_issue = !skid_valid && (!resp_valid || resp_ready);
endmodule

module sram_1rw1r_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_WMASKS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w_req_valid,
    output logic                  w_req_ready,
    input  logic [ADDR_WIDTH-1:0] w_req_addr,
    input  logic [DATA_WIDTH-1:0] w_req_data,
    input  logic [NUM_WMASKS-1:0] w_req_mask,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    output logic                  a_resp_valid,
    input  logic                  a_resp_ready,
    output logic [DATA_WIDTH-1:0] a_resp_data,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    output logic                  b_resp_valid,
    input  logic                  b_resp_ready,
    output logic [DATA_WIDTH-1:0] b_resp_data,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    typedef enum logic {RR_W = 1'b0, RR_A = 1'b1} rr_t;

    rr_t  rr, rr_next;
    logic a_can, b_can;
    logic a_elig, b_elig;
    logic grant_w, grant_a, grant_b;

    assign a_elig = a_req_valid && a_can;
    assign b_elig = b_req_valid && b_can;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr <= RR_W;
        else       rr <= rr_next;
    end

    always_comb begin
        rr_next = rr;
        grant_w = 1'b0;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (w_req_valid && a_elig) begin
                if (rr == RR_W) begin
                    grant_w = 1'b1;
                    rr_next = RR_A;
                end else begin
                    grant_a = 1'b1;
                    rr_next = RR_W;
                end
            end else begin
                grant_w = w_req_valid;
                grant_a = a_elig;
            end
            // Port 1 must not read the word port 0 is writing on the same edge.
            grant_b = b_elig && !(grant_w && (b_req_addr == w_req_addr));
        end
    end

    assign w_req_ready = grant_w;
    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (grant_w) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = w_req_mask;
            sram_addr0  = w_req_addr;
            sram_din0   = w_req_data;
        end else if (grant_a) begin
            sram_csb0  = 1'b0;
            sram_addr0 = a_req_addr;
        end
    end

    assign sram_csb1  = !grant_b;
    assign sram_addr1 = grant_b ? b_req_addr : '0;

    sram_1rw1r_resp_slot #(.DATA_WIDTH(DATA_WIDTH)) a_slot (
        .clk        (clk),
        .reset      (reset),
        .issue      (grant_a),
        .sram_dout  (sram_dout0),
        .resp_ready (a_resp_ready),
        .resp_valid (a_resp_valid),
        .resp_data  (a_resp_data),
        .can_issue  (a_can)
    );

    sram_1rw1r_resp_slot #(.DATA_WIDTH(DATA_WIDTH)) b_slot (
        .clk        (clk),
        .reset      (reset),
        .issue      (grant_b),
        .sram_dout  (sram_dout1),
        .resp_ready (b_resp_ready),
        .resp_valid (b_resp_valid),
        .resp_data  (b_resp_data),
        .can_issue  (b_can)
    );
endmodule

// File: tb/tb_sram_1rw1r_port_arbiter.sv
// Self-checking bench for sram_1rw1r_port_arbiter: behavioural 1RW+1R macro, reference memory
// and per-stream response scoreboards, plus directed scenario tasks.

module tb_sram_1rw1r_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          w_req_valid = 1'b0, w_req_ready;
    logic [AW-1:0] w_req_addr = '0;
    logic [DW-1:0] w_req_data = '0;
    logic [DW-1:0] w_req_mask = '0;
    logic          a_req_valid = 1'b0, a_req_ready;
    logic [AW-1:0] a_req_addr = '0;
    logic          a_resp_valid, a_resp_ready = 1'b0;
    logic [DW-1:0] a_resp_data;
    logic          b_req_valid = 1'b0, b_req_ready;
    logic [AW-1:0] b_req_addr = '0;
    logic          b_resp_valid, b_resp_ready = 1'b0;
    logic [DW-1:0] b_resp_data;
    logic          sram_csb0, sram_web0, sram_csb1;
    logic [DW-1:0] sram_wmask0, sram_din0;
    logic [DW-1:0] sram_dout0 = '0, sram_dout1 = '0;
    logic [AW-1:0] sram_addr0, sram_addr1;

    int errors = 0;
    int checks = 0;
    int a_pops = 0;
    logic [DW-1:0] last_a = '0, last_b = '0;
    logic [DW-1:0] a_q[$];
    logic [DW-1:0] b_q[$];
    bit   [DW-1:0] mem     [0:511];
    bit   [DW-1:0] ref_mem [0:511];

    always #5 clk = ~clk;

    sram_1rw1r_port_arbiter dut (
        .clk(clk), .reset(reset),
        .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_addr(w_req_addr),
        .w_req_data(w_req_data), .w_req_mask(w_req_mask),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
        .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready), .a_resp_data(a_resp_data),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
        .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready), .b_resp_data(b_resp_data),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    // Behavioural macro: controls sampled on the rising edge, read data valid during the next cycle.
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0)
                mem[sram_addr0] <= (mem[sram_addr0] & ~sram_wmask0) | (sram_din0 & sram_wmask0);
            else
                sram_dout0 <= mem[sram_addr0];
        end
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    // Inputs only change just after a rising edge, so the falling edge sees what the next edge fires.
    always @(negedge clk) begin
        if (reset) begin
            a_q.delete();
            b_q.delete();
        end else begin
            if (a_resp_valid && a_resp_ready) begin
                checks++;
                if (a_q.size() == 0) begin
                    errors++;
                    $display("FAIL a_resp_unexpected got=%h expected no response", a_resp_data);
                end else begin
                    logic [DW-1:0] exp;
                    exp = a_q.pop_front();
                    if (a_resp_data !== exp) begin
                        errors++;
                        $display("FAIL a_resp_data got=%h expected=%h", a_resp_data, exp);
                    end
                end
                last_a = a_resp_data;
                a_pops++;
            end
            if (b_resp_valid && b_resp_ready) begin
                checks++;
                if (b_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_resp_unexpected got=%h expected no response", b_resp_data);
                end else begin
                    logic [DW-1:0] exp;
                    exp = b_q.pop_front();
                    if (b_resp_data !== exp) begin
                        errors++;
                        $display("FAIL b_resp_data got=%h expected=%h", b_resp_data, exp);
                    end
                end
                last_b = b_resp_data;
            end
            if (w_req_valid && w_req_ready)
                ref_mem[w_req_addr] = (ref_mem[w_req_addr] & ~w_req_mask) | (w_req_data & w_req_mask);
            if (a_req_valid && a_req_ready) a_q.push_back(ref_mem[a_req_addr]);
            if (b_req_valid && b_req_ready) b_q.push_back(ref_mem[b_req_addr]);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [DW-1:0] mask);
        bit fired = 0;
        w_req_addr = addr; w_req_data = data; w_req_mask = mask; w_req_valid = 1'b1;
        for (int i = 0; i < 20 && !fired; i++) begin
            #1;
            fired = w_req_ready;
            step();
        end
        w_req_valid = 1'b0;
        checks++;
        if (!fired) begin
            errors++;
            $display("FAIL write_accept addr=%0d got=not accepted expected=accepted", addr);
        end
    endtask

    task automatic do_read_a(input logic [AW-1:0] addr);
        bit fired = 0;
        a_req_addr = addr; a_req_valid = 1'b1;
        for (int i = 0; i < 20 && !fired; i++) begin
            #1;
            fired = a_req_ready;
            step();
        end
        a_req_valid = 1'b0;
        checks++;
        if (!fired) begin
            errors++;
            $display("FAIL a_read_accept addr=%0d got=not accepted expected=accepted", addr);
        end
    endtask

    task automatic do_read_b(input logic [AW-1:0] addr);
        bit fired = 0;
        b_req_addr = addr; b_req_valid = 1'b1;
        for (int i = 0; i < 20 && !fired; i++) begin
            #1;
            fired = b_req_ready;
            step();
        end
        b_req_valid = 1'b0;
        checks++;
        if (!fired) begin
            errors++;
            $display("FAIL b_read_accept addr=%0d got=not accepted expected=accepted", addr);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((a_q.size() != 0 || b_q.size() != 0 || a_resp_valid || b_resp_valid) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (a_q.size() != 0 || b_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d/%0d pending expected=0/0", a_q.size(), b_q.size());
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        w_req_valid = 1'b1; a_req_valid = 1'b1; b_req_valid = 1'b1;
        w_req_addr = 9'd3; a_req_addr = 9'd4; b_req_addr = 9'd5;
        repeat (2) step();
        checks++;
        if ({w_req_ready, a_req_ready, b_req_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_readies got=%b expected=000", {w_req_ready, a_req_ready, b_req_ready});
        end
        checks++;
        if ({sram_csb0, sram_web0, sram_csb1} !== 3'b111 || sram_addr0 !== '0 || sram_din0 !== '0
            || sram_wmask0 !== '0 || sram_addr1 !== '0) begin
            errors++;
            $display("FAIL reset_sram got=csb0 %b web0 %b csb1 %b addr0 %h addr1 %h expected=1 1 1 0 0",
                     sram_csb0, sram_web0, sram_csb1, sram_addr0, sram_addr1);
        end
        checks++;
        if (a_resp_valid !== 1'b0 || b_resp_valid !== 1'b0 || a_resp_data !== '0 || b_resp_data !== '0) begin
            errors++;
            $display("FAIL reset_resp got=%b %b %h %h expected=0 0 0 0",
                     a_resp_valid, b_resp_valid, a_resp_data, b_resp_data);
        end
        w_req_valid = 1'b0; a_req_valid = 1'b0; b_req_valid = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        a_resp_ready = 1'b0; b_resp_ready = 1'b1;
        w_req_addr = 9'd5; w_req_data = 32'h12345678; w_req_mask = 32'hFFFFFFFF; w_req_valid = 1'b1;
        #1;
        checks++;
        if (w_req_ready !== 1'b1 || sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== 9'd5
            || sram_din0 !== 32'h12345678 || sram_wmask0 !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL write_pins got=rdy %b csb0 %b web0 %b addr0 %0d din0 %h expected=1 0 0 5 12345678",
                     w_req_ready, sram_csb0, sram_web0, sram_addr0, sram_din0);
        end
        step();
        w_req_valid = 1'b0;
        a_req_addr = 9'd5; a_req_valid = 1'b1;
        #1;
        checks++;
        if (a_req_ready !== 1'b1 || sram_csb0 !== 1'b0 || sram_web0 !== 1'b1 || sram_wmask0 !== '0
            || sram_addr0 !== 9'd5) begin
            errors++;
            $display("FAIL read_pins got=rdy %b csb0 %b web0 %b wmask0 %h expected=1 0 1 0",
                     a_req_ready, sram_csb0, sram_web0, sram_wmask0);
        end
        step();
        a_req_valid = 1'b0;
        checks++;
        if (a_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL a_latency_early got=%b expected=0", a_resp_valid);
        end
        step();
        checks++;
        if (a_resp_valid !== 1'b1 || a_resp_data !== 32'h12345678) begin
            errors++;
            $display("FAIL a_latency got=%b %h expected=1 12345678", a_resp_valid, a_resp_data);
        end
        a_resp_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_mask();
        do_write(9'd9, 32'h00000000, 32'hFFFFFFFF);
        do_write(9'd9, 32'hFFFFFFFF, 32'h0000FFFF);
        do_read_a(9'd9);
        wait_drain();
        checks++;
        if (last_a !== 32'h0000FFFF) begin
            errors++;
            $display("FAIL mask_partial got=%h expected=0000ffff", last_a);
        end
        do_write(9'd9, 32'hDEADBEEF, 32'h00000000);
        do_read_a(9'd9);
        wait_drain();
        checks++;
        if (last_a !== 32'h0000FFFF) begin
            errors++;
            $display("FAIL mask_zero got=%h expected=0000ffff", last_a);
        end
    endtask

    task automatic test_arbitration();
        apply_reset();
        a_resp_ready = 1'b1;
        a_req_addr = 9'd30; a_req_valid = 1'b1;
        w_req_mask = 32'hFFFFFFFF; w_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic exp_w;
            exp_w = (i % 2 == 0);
            w_req_addr = 9'(20 + i);
            w_req_data = 32'h11110000 + 32'(i);
            #1;
            checks++;
            if (w_req_ready !== exp_w || a_req_ready !== !exp_w) begin
                errors++;
                $display("FAIL rr_grant cycle=%0d got=w%b a%b expected=w%b a%b",
                         i, w_req_ready, a_req_ready, exp_w, !exp_w);
            end
            step();
        end
        w_req_valid = 1'b0; a_req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_collision();
        b_resp_ready = 1'b1;
        do_write(9'd8, 32'h0BADF00D, 32'hFFFFFFFF);
        w_req_addr = 9'd7; w_req_data = 32'hA5A5A5A5; w_req_mask = 32'hFFFFFFFF; w_req_valid = 1'b1;
        b_req_addr = 9'd7; b_req_valid = 1'b1;
        #1;
        checks++;
        if (w_req_ready !== 1'b1 || b_req_ready !== 1'b0 || sram_csb1 !== 1'b1) begin
            errors++;
            $display("FAIL collision_block got=w%b b%b csb1 %b expected=w1 b0 csb1 1",
                     w_req_ready, b_req_ready, sram_csb1);
        end
        step();
        w_req_valid = 1'b0;
        #1;
        checks++;
        if (b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL collision_retry got=%b expected=1", b_req_ready);
        end
        step();
        b_req_valid = 1'b0;
        wait_drain();
        checks++;
        if (last_b !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL collision_data got=%h expected=a5a5a5a5", last_b);
        end
        w_req_addr = 9'd7; w_req_data = 32'h5A5A5A5A; w_req_valid = 1'b1;
        b_req_addr = 9'd8; b_req_valid = 1'b1;
        #1;
        checks++;
        if (w_req_ready !== 1'b1 || b_req_ready !== 1'b1 || sram_addr1 !== 9'd8) begin
            errors++;
            $display("FAIL parallel_fire got=w%b b%b addr1 %0d expected=w1 b1 addr1 8",
                     w_req_ready, b_req_ready, sram_addr1);
        end
        step();
        w_req_valid = 1'b0; b_req_valid = 1'b0;
        wait_drain();
        checks++;
        if (last_b !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL parallel_data got=%h expected=0badf00d", last_b);
        end
    endtask

    task automatic test_backpressure();
        int pops_before;
        a_resp_ready = 1'b0;
        do_read_a(9'd5);
        step();
        a_req_addr = 9'd9; a_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_req_ready !== 1'b0 || a_resp_valid !== 1'b1 || a_resp_data !== 32'h12345678) begin
                errors++;
                $display("FAIL stall cycle=%0d got=rdy %b valid %b data %h expected=0 1 12345678",
                         i, a_req_ready, a_resp_valid, a_resp_data);
            end
            step();
        end
        pops_before = a_pops;
        a_resp_ready = 1'b1;
        #1;
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got=%b expected=1", a_req_ready);
        end
        step();
        a_req_valid = 1'b0;
        wait_drain();
        checks++;
        if (a_pops !== pops_before + 2 || last_a !== 32'h0000FFFF) begin
            errors++;
            $display("FAIL stall_count got=%0d pops last %h expected=%0d pops last 0000ffff",
                     a_pops - pops_before, last_a, 2);
        end
    endtask

    task automatic test_reset_midflight();
        b_resp_ready = 1'b1;
        do_read_b(9'd8);
        wait_drain();
        do_read_b(9'd7);
        reset = 1'b1;
        #1;
        checks++;
        if (b_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_now got=%b expected=0", b_resp_valid);
        end
        b_req_valid = 1'b1; w_req_valid = 1'b1;
        step();
        step();
        checks++;
        if (b_resp_valid !== 1'b0 || b_resp_data !== '0 || b_req_ready !== 1'b0 || w_req_ready !== 1'b0
            || sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1 || sram_web0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_midflight got=bv %b bd %h brdy %b csb0 %b csb1 %b expected=0 0 0 1 1",
                     b_resp_valid, b_resp_data, b_req_ready, sram_csb0, sram_csb1);
        end
        b_req_valid = 1'b0; w_req_valid = 1'b0;
        reset = 1'b0;
        step();
        step();
        checks++;
        if (b_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_late_resp got=%b expected=0", b_resp_valid);
        end
        do_read_b(9'd7);
        wait_drain();
        checks++;
        if (last_b !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL post_reset_read got=%h expected=5a5a5a5a", last_b);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_mask();
        test_arbitration();
        test_collision();
        test_backpressure();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
